// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // Shift-add-3: a digit at or above the threshold is corrected before shifting
  localparam bcd_digit_t BCD_ADJ_THRESH = 4'd5;
  localparam bcd_digit_t BCD_ADJ_ADD    = 4'd3;

  // Ceiling log2, used to size the bit counter
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit's combinational add-3 correction (digit >= 5 -> digit + 3).
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  bcd_digit_t digit,
  output bcd_digit_t adjusted
);

  // Correction applied before the digit chain shifts left
  always_comb begin
    adjusted = digit;
    if (digit >= BCD_ADJ_THRESH) adjusted = digit + BCD_ADJ_ADD;
  end

endmodule

// File: rtl/bin_bcd_seq_converter.sv
// Multi-cycle double-dabble binary-to-BCD converter, one input bit per clock.
// Optional leading-zero mask output enabled by defining BCD_BLANK_EN.
module bin_bcd_seq_converter
  import bcd_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_DIGITS = 10,
  parameter bit SIGNED     = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   binary,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    neg,
  output logic                    overflow
`ifdef BCD_BLANK_EN
  ,
  output logic [NUM_DIGITS-1:0]   blank
`endif
);

  localparam int CNT_W = clog2(DATA_WIDTH);
  localparam int BCD_W = 4 * NUM_DIGITS;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [DATA_WIDTH-1:0]   mag;
  logic [BCD_W-1:0]        adj_vec;

  // Per-digit add-3 correction on the current digit registers
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit    (bcd[4*k +: 4]),
      .adjusted (adj_vec[4*k +: 4])
    );
  end

`ifdef BCD_BLANK_EN
  logic [NUM_DIGITS-1:0] blank_nxt;

  // Digit k is blank when it and every higher digit are zero; units never blank
  always_comb begin
    logic all_zero;
    blank_nxt = '0;
    all_zero  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      all_zero     = all_zero & (bcd[4*k +: 4] == 4'd0);
      blank_nxt[k] = all_zero;
    end
  end
`endif

  // Control FSM with the datapath registers; all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      bcd       <= '0;
      neg       <= 1'b0;
      overflow  <= 1'b0;
      cnt       <= '0;
      mag       <= '0;
`ifdef BCD_BLANK_EN
      blank     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Most-negative input negates to exactly 2^(DATA_WIDTH-1), still fits unsigned
            if (SIGNED && binary[DATA_WIDTH-1]) begin
              mag <= ~binary + DATA_WIDTH'(1);
              neg <= 1'b1;
            end else begin
              mag <= binary;
              neg <= 1'b0;
            end
            bcd      <= '0;
            overflow <= 1'b0;
            cnt      <= CNT_W'(DATA_WIDTH - 1);
            in_ready <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          // Corrected digits shift left, magnitude MSB feeds the units digit
          bcd      <= {adj_vec[BCD_W-2:0], mag[DATA_WIDTH-1]};
          overflow <= overflow | adj_vec[BCD_W-1];
          mag      <= {mag[DATA_WIDTH-2:0], 1'b0};
          cnt      <= cnt - CNT_W'(1);
          if (cnt == '0) state <= DONE;
        end
        DONE: begin
          // First DONE cycle publishes the result; afterwards wait for the consumer
          if (!out_valid) begin
            out_valid <= 1'b1;
`ifdef BCD_BLANK_EN
            blank     <= blank_nxt;
`endif
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
`ifdef BCD_BLANK_EN
            blank     <= '0;
`endif
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_bcd_seq_converter.sv
// Directed bench: three converters (unsigned 10 digits, signed 10 digits,
// unsigned 4 digits) share one input stream and handshake.
module tb_bin_bcd_seq_converter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] binary;
  logic        out_ready;

  logic        uns_in_ready, uns_out_valid, uns_neg, uns_ovf;
  logic [39:0] uns_bcd;
  logic        sgn_in_ready, sgn_out_valid, sgn_neg, sgn_ovf;
  logic [39:0] sgn_bcd;
  logic        o4_in_ready, o4_out_valid, o4_neg, o4_ovf;
  logic [15:0] o4_bcd;
`ifdef BCD_BLANK_EN
  logic [9:0]  uns_blank, sgn_blank;
  logic [3:0]  o4_blank;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  bin_bcd_seq_converter #(.DATA_WIDTH(32), .NUM_DIGITS(10), .SIGNED(1'b0)) u_uns (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(uns_in_ready), .binary(binary),
    .out_valid(uns_out_valid), .out_ready(out_ready), .bcd(uns_bcd), .neg(uns_neg),
    .overflow(uns_ovf)
`ifdef BCD_BLANK_EN
    , .blank(uns_blank)
`endif
  );

  bin_bcd_seq_converter #(.DATA_WIDTH(32), .NUM_DIGITS(10), .SIGNED(1'b1)) u_sgn (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sgn_in_ready), .binary(binary),
    .out_valid(sgn_out_valid), .out_ready(out_ready), .bcd(sgn_bcd), .neg(sgn_neg),
    .overflow(sgn_ovf)
`ifdef BCD_BLANK_EN
    , .blank(sgn_blank)
`endif
  );

  bin_bcd_seq_converter #(.DATA_WIDTH(32), .NUM_DIGITS(4), .SIGNED(1'b0)) u_o4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o4_in_ready), .binary(binary),
    .out_valid(o4_out_valid), .out_ready(out_ready), .bcd(o4_bcd), .neg(o4_neg),
    .overflow(o4_ovf)
`ifdef BCD_BLANK_EN
    , .blank(o4_blank)
`endif
  );

  // Offer one value, then wait (bounded) for the result; lat = edges after accept
  task automatic start_conv(input logic [31:0] v, output int lat);
    @(negedge clk);
    binary   = v;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    binary   = 32'hDEAD_BEEF;
    lat = 0;
    while (!uns_out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // Accept the result with a one-cycle out_ready pulse
  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; binary = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    nvec++; if (uns_in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready got %b exp 1", uns_in_ready); end
    nvec++; if (uns_out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid got %b exp 0", uns_out_valid); end
    nvec++; if (uns_bcd !== 40'h0) begin nerr++; $display("FAIL reset_bcd got %h exp 0", uns_bcd); end
    nvec++; if (sgn_neg !== 1'b0 || sgn_ovf !== 1'b0) begin nerr++; $display("FAIL reset_neg_ovf got %b%b exp 00", sgn_neg, sgn_ovf); end
  endtask

  task automatic test_unsigned();
    int lat;
    start_conv(32'd12345, lat);
    nvec++; if (lat !== 33) begin nerr++; $display("FAIL latency_12345 got %0d exp 33", lat); end
    nvec++; if (uns_bcd !== 40'h0000012345) begin nerr++; $display("FAIL uns_12345 got %h exp 0000012345", uns_bcd); end
    nvec++; if (uns_neg !== 1'b0 || uns_ovf !== 1'b0) begin nerr++; $display("FAIL uns_12345_flags got %b%b exp 00", uns_neg, uns_ovf); end
    nvec++; if (o4_bcd !== 16'h2345 || o4_ovf !== 1'b1) begin nerr++; $display("FAIL o4_12345 got %h/%b exp 2345/1", o4_bcd, o4_ovf); end
    release_result();
    nvec++; if (uns_in_ready !== 1'b1 || uns_out_valid !== 1'b0) begin nerr++; $display("FAIL release_12345 got rdy%b vld%b exp rdy1 vld0", uns_in_ready, uns_out_valid); end
    start_conv(32'd0, lat);
    nvec++; if (uns_bcd !== 40'h0 || sgn_bcd !== 40'h0 || sgn_neg !== 1'b0) begin nerr++; $display("FAIL zero got %h/%h/%b exp 0/0/0", uns_bcd, sgn_bcd, sgn_neg); end
`ifdef BCD_BLANK_EN
    nvec++; if (uns_blank !== 10'b11_1111_1110) begin nerr++; $display("FAIL blank_zero got %b exp 1111111110", uns_blank); end
`endif
    release_result();
  endtask

  task automatic test_full_scale();
    int lat;
    start_conv(32'hFFFF_FFFF, lat);
    nvec++; if (uns_bcd !== 40'h4294967295 || uns_ovf !== 1'b0) begin nerr++; $display("FAIL uns_full got %h/%b exp 4294967295/0", uns_bcd, uns_ovf); end
    nvec++; if (sgn_bcd !== 40'h1 || sgn_neg !== 1'b1) begin nerr++; $display("FAIL sgn_minus1 got %h/%b exp 1/1", sgn_bcd, sgn_neg); end
    nvec++; if (o4_bcd !== 16'h7295 || o4_ovf !== 1'b1) begin nerr++; $display("FAIL o4_full got %h/%b exp 7295/1", o4_bcd, o4_ovf); end
    release_result();
  endtask

  task automatic test_signed();
    int lat;
    start_conv(32'h8000_0000, lat);
    nvec++; if (sgn_bcd !== 40'h2147483648 || sgn_neg !== 1'b1 || sgn_ovf !== 1'b0) begin nerr++; $display("FAIL sgn_minmost got %h/%b/%b exp 2147483648/1/0", sgn_bcd, sgn_neg, sgn_ovf); end
    nvec++; if (uns_bcd !== 40'h2147483648 || uns_neg !== 1'b0) begin nerr++; $display("FAIL uns_2p31 got %h/%b exp 2147483648/0", uns_bcd, uns_neg); end
    release_result();
    start_conv(32'hFFFF_FFFB, lat);
    nvec++; if (sgn_bcd !== 40'h5 || sgn_neg !== 1'b1) begin nerr++; $display("FAIL sgn_minus5 got %h/%b exp 5/1", sgn_bcd, sgn_neg); end
    release_result();
  endtask

  task automatic test_overflow();
    int lat;
    start_conv(32'd10000, lat);
    nvec++; if (o4_bcd !== 16'h0000 || o4_ovf !== 1'b1) begin nerr++; $display("FAIL o4_10000 got %h/%b exp 0000/1", o4_bcd, o4_ovf); end
    release_result();
    start_conv(32'd9999, lat);
    nvec++; if (o4_bcd !== 16'h9999 || o4_ovf !== 1'b0) begin nerr++; $display("FAIL o4_9999 got %h/%b exp 9999/0", o4_bcd, o4_ovf); end
    release_result();
  endtask

  task automatic test_handshake();
    int lat;
    start_conv(32'd777, lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0];
      binary   = 32'd555;
      @(posedge clk);
      #1;
      nvec++; if (uns_out_valid !== 1'b1 || uns_bcd !== 40'h777 || uns_in_ready !== 1'b0) begin nerr++; $display("FAIL hold_%0d got vld%b %h rdy%b exp vld1 777 rdy0", i, uns_out_valid, uns_bcd, uns_in_ready); end
    end
    @(negedge clk);
    in_valid = 1'b0;
    release_result();
    @(posedge clk);
    #1;
    nvec++; if (uns_out_valid !== 1'b0 || uns_in_ready !== 1'b1) begin nerr++; $display("FAIL no_queue got vld%b rdy%b exp vld0 rdy1", uns_out_valid, uns_in_ready); end
`ifdef BCD_BLANK_EN
    nvec++; if (uns_blank !== 10'b0) begin nerr++; $display("FAIL blank_idle got %b exp 0", uns_blank); end
`endif
    start_conv(32'd42, lat);
    nvec++; if (uns_bcd !== 40'h42 || lat !== 33) begin nerr++; $display("FAIL after_hold got %h lat%0d exp 42 lat33", uns_bcd, lat); end
    release_result();
  endtask

  task automatic test_reset_mid_shift();
    int lat;
    @(negedge clk);
    binary   = 32'hFFFF_FFFB;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (31) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    nvec++; if (sgn_in_ready !== 1'b1 || sgn_out_valid !== 1'b0) begin nerr++; $display("FAIL midrst_hs got rdy%b vld%b exp rdy1 vld0", sgn_in_ready, sgn_out_valid); end
    nvec++; if (uns_bcd !== 40'h0 || sgn_neg !== 1'b0 || o4_ovf !== 1'b0) begin nerr++; $display("FAIL midrst_data got %h/%b/%b exp 0/0/0", uns_bcd, sgn_neg, o4_ovf); end
    start_conv(32'd305, lat);
    nvec++; if (uns_bcd !== 40'h305 || sgn_neg !== 1'b0 || lat !== 33) begin nerr++; $display("FAIL post_rst got %h/%b lat%0d exp 305/0 lat33", uns_bcd, sgn_neg, lat); end
`ifdef BCD_BLANK_EN
    nvec++; if (uns_blank !== 10'b11_1111_1000) begin nerr++; $display("FAIL blank_305 got %b exp 1111111000", uns_blank); end
`endif
    release_result();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_unsigned();
    test_full_scale();
    test_signed();
    test_overflow();
    test_handshake();
    test_reset_mid_shift();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
